aes_cipher: RTL

AES_CIPHER -- requirements
Module: aes_cipher

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_round.sv | 38 +++
 rtl/aes_cipher.sv | 92 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, block type, cipher FSM states and
// the forward S-box used by both the cipher datapath and key expansion.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } cipher_state_t;

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. final_i selects the last-round form without MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] st_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte n of the block is row n%4, column n/4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb[gi] = sbox(st_i[127-8*gi -: 8]);
    assign sr[gi] = sb[(gi % 4) + 4*(((gi / 4) + (gi % 4)) % 4)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi + 0];
    assign a1 = sr[4*gi + 1];
    assign a2 = sr[4*gi + 2];
    assign a3 = sr[4*gi + 3];
    assign mc[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_ark
    assign st_o[127-8*gi -: 8] = (final_i ? sr[gi] : mc[gi]) ^ rk_i[127-8*gi -: 8];
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryptor, one round per cycle through a shared aes_round.
// Optional synchronous abort input flush_i when AES_CIPHER_FLUSH_EN is defined.
module aes_cipher
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [127:0]      block_i,
  input  logic [NR:0][127:0] round_key_i,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef AES_CIPHER_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic [127:0]      block_o
);

  cipher_state_t state_reg, state_next;
  logic [3:0]    rnd_reg, rnd_next;
  block_t        st_reg, st_next;
  block_t        round_out;
  logic          flush;

`ifdef AES_CIPHER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  aes_round u_round (
    .st_i    (st_reg),
    .rk_i    (round_key_i[rnd_reg]),
    .final_i (rnd_reg == 4'(NR)),
    .st_o    (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rnd_reg   <= 4'd0;
      st_reg    <= '0;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      st_reg    <= st_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rnd_next   = rnd_reg;
    st_next    = st_reg;
    ready_o    = (state_reg == IDLE);
    valid_o    = (state_reg == DONE);
    block_o    = st_reg;

    if (flush) begin
      state_next = IDLE;
      rnd_next   = 4'd0;
      st_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            st_next    = block_i ^ round_key_i[0];
            rnd_next   = 4'd1;
            state_next = ROUND;
          end
        end
        ROUND: begin
          st_next = round_out;
          if (rnd_reg == 4'(NR)) begin
            state_next = DONE;
          end else begin
            rnd_next = rnd_reg + 4'd1;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
